// File: rtl/cpu_mul_combine.sv
// cpu_mul_combine: two-stage combine of 16x16 partial products into the low 32-bit product; CPU_MUL_COMBINE_STATS_EN enables the completion counter
module cpu_mul_combine #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_p1,
  input  logic [31:0]      in_p2,
  input  logic [31:0]      in_p3,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [31:0]      stat_count
);
  logic             r_a_valid, r_b_valid;
  logic [31:0]      r_a_p1, r_b_result;
  logic [15:0]      r_a_cross;
  logic [TAG_W-1:0] r_a_tag, r_b_tag;
  logic             w_b_adv, w_a_adv, w_accept;
  logic [15:0]      w_cross;
  logic             w_unused;
  always_comb begin
    w_b_adv  = !r_b_valid || out_ready;
    w_a_adv  = r_a_valid && w_b_adv;
    in_ready = (!r_a_valid || w_b_adv) && !flush;
    w_accept = in_valid && in_ready;
    w_cross  = in_p2[15:0] + in_p3[15:0];
    w_unused = ^{in_p2[31:16], in_p3[31:16]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_valid  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_a_p1     <= '0;
      r_a_cross  <= '0;
      r_a_tag    <= '0;
      r_b_result <= '0;
      r_b_tag    <= '0;
    end else begin
      r_a_valid <= !flush && (w_accept || (r_a_valid && !w_b_adv));
      r_b_valid <= !flush && (w_b_adv ? r_a_valid : r_b_valid);
      if (w_accept) begin
        r_a_p1    <= in_p1;
        r_a_cross <= w_cross;
        r_a_tag   <= in_tag;
      end
      if (w_a_adv) begin
        r_b_result <= r_a_p1 + {r_a_cross, 16'h0000};
        r_b_tag    <= r_a_tag;
      end
    end
  end
  assign out_valid  = r_b_valid;
  assign out_result = r_b_result;
  assign out_tag    = r_b_tag;
  assign busy       = r_a_valid | r_b_valid;
`ifdef CPU_MUL_COMBINE_STATS_EN
  logic [31:0] r_stat_count;
  always_ff @(posedge clk) begin
    if (reset) r_stat_count <= '0;
    else if (r_b_valid && out_ready) r_stat_count <= r_stat_count + 32'd1;
  end
  assign stat_count = r_stat_count;
`else
  assign stat_count = 32'h0;
`endif
endmodule
